tls_sni_extractor: RTL and testbench

//  Producer side of the 2-bytes/cycle SNI matcher interface. Parses one TLS ClientHello per

---
 rtl/tls_sni_extractor.sv | 181 ++++++++++++++++++
 tb/tb_tls_sni_extractor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tls_sni_extractor.sv
// tls_sni_extractor: parses one TLS ClientHello per packet and streams the SNI host_name as byte pairs.
// Build option: define SNI_LOWERCASE_EN to fold ASCII uppercase host_name bytes to lowercase.
module tls_sni_extractor #(
   parameter int         MAX_SNI_LEN = 255,
   parameter logic [7:0] PAD_BYTE    = 8'h00
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte,
   input  logic        i_byte_last,
   output logic        o_match_rst,
   output logic        o_match_data_valid,
   output logic [15:0] o_match_data,
   output logic        o_sni_done,
   output logic        o_sni_found,
   output logic        o_parse_err,
   output logic [15:0] o_sni_len
);
   typedef enum logic [4:0] {
      IDLE, REC_HDR, HS_HDR, FIXED, SID_LEN, SID_SKIP, CS_LEN, CS_SKIP, CM_LEN, CM_SKIP,
      EXT_TOT, EXT_TYPE, EXT_LEN, EXT_SKIP, LIST_LEN, NAME_TYPE, NAME_LEN, NAME, DONE, NOSNI, ERR
   } state_t;
   state_t      state_q, state_d, cur, nxt;
   logic [15:0] cnt_q, cnt_d, cnt, ext_q, ext_d, name_len_q, name_len_d, len_q, len_d, data_q, data_d;
   logic [15:0] val1, val2;
   logic [7:0]  acc_q, acc_d, hi_q, hi_d, nb;
   logic        typ0_q, typ0_d, half_q, half_d, fin_q, fin_d, mrst_q, mrst_d, dv_q, dv_d;
   logic        done_q, done_d, found_q, found_d, err_q, err_d, fe;
   // IDLE behaves as the first byte of the record header
   assign cur  = (state_q == IDLE) ? REC_HDR : state_q;
   assign cnt  = (state_q == IDLE) ? 16'd5 : cnt_q;
   assign fe   = cnt == 16'd1;
   assign val1 = {8'h00, i_byte};
   assign val2 = {acc_q, i_byte};
`ifdef SNI_LOWERCASE_EN
   assign nb = (i_byte >= 8'h41 && i_byte <= 8'h5A) ? (i_byte | 8'h20) : i_byte;
`else
   assign nb = i_byte;
`endif
   // next-state, field counting, pair packing and verdict generation
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      ext_d      = ext_q;
      typ0_d     = typ0_q;
      name_len_d = name_len_q;
      half_d     = half_q;
      hi_d       = hi_q;
      data_d     = data_q;
      nxt        = cur;
      fin_d      = 1'b0;
      mrst_d     = 1'b0;
      dv_d       = 1'b0;
      done_d     = fin_q;
      found_d    = fin_q;
      err_d      = 1'b0;
      len_d      = fin_q ? name_len_q : 16'd0;
      if (i_byte_valid) begin
         cnt_d = cnt - 16'd1;
         acc_d = i_byte;
         case (cur)
            REC_HDR: begin
               if (cnt == 16'd5 && i_byte != 8'h16) nxt = ERR;
               else if (fe) begin nxt = HS_HDR; cnt_d = 16'd4; end
            end
            HS_HDR: begin
               if (cnt == 16'd4 && i_byte != 8'h01) nxt = ERR;
               else if (fe) begin nxt = FIXED; cnt_d = 16'd34; end
            end
            FIXED:    if (fe) begin nxt = SID_LEN; cnt_d = 16'd1; end
            SID_LEN:  begin nxt = (val1 == 16'd0) ? CS_LEN : SID_SKIP; cnt_d = (val1 == 16'd0) ? 16'd2 : val1; end
            SID_SKIP: if (fe) begin nxt = CS_LEN; cnt_d = 16'd2; end
            CS_LEN:   if (fe) begin nxt = (val2 == 16'd0) ? CM_LEN : CS_SKIP; cnt_d = (val2 == 16'd0) ? 16'd1 : val2; end
            CS_SKIP:  if (fe) begin nxt = CM_LEN; cnt_d = 16'd1; end
            CM_LEN:   begin nxt = (val1 == 16'd0) ? EXT_TOT : CM_SKIP; cnt_d = (val1 == 16'd0) ? 16'd2 : val1; end
            CM_SKIP:  if (fe) begin nxt = EXT_TOT; cnt_d = 16'd2; end
            EXT_TOT: begin
               if (fe) begin
                  ext_d = val2;
                  nxt   = (val2 == 16'd0) ? NOSNI : EXT_TYPE;
                  cnt_d = 16'd2;
               end
            end
            EXT_TYPE: begin
               ext_d = ext_q - 16'd1;
               if (fe) begin typ0_d = val2 == 16'd0; nxt = EXT_LEN; cnt_d = 16'd2; end
            end
            EXT_LEN: begin
               ext_d = ext_q - 16'd1;
               if (fe) begin
                  nxt   = typ0_q ? LIST_LEN : (val2 != 16'd0) ? EXT_SKIP : (ext_q == 16'd1) ? NOSNI : EXT_TYPE;
                  cnt_d = (typ0_q || val2 == 16'd0) ? 16'd2 : val2;
               end
            end
            EXT_SKIP: begin
               ext_d = ext_q - 16'd1;
               if (fe) begin nxt = (ext_q == 16'd1) ? NOSNI : EXT_TYPE; cnt_d = 16'd2; end
            end
            LIST_LEN:  if (fe) begin nxt = NAME_TYPE; cnt_d = 16'd1; end
            NAME_TYPE: begin nxt = (i_byte != 8'h00) ? ERR : NAME_LEN; cnt_d = 16'd2; end
            NAME_LEN: begin
               if (fe && val2 > 16'(MAX_SNI_LEN)) nxt = ERR;
               else if (fe) begin
                  mrst_d     = 1'b1;
                  name_len_d = val2;
                  half_d     = 1'b0;
                  cnt_d      = val2;
                  nxt        = (val2 == 16'd0) ? DONE : NAME;
                  fin_d      = val2 == 16'd0;
               end
            end
            NAME: begin
               dv_d   = half_q | fe;
               data_d = half_q ? {hi_q, nb} : fe ? {nb, PAD_BYTE} : data_q;
               hi_d   = nb;
               half_d = !half_q && !fe;
               if (fe) begin nxt = DONE; fin_d = 1'b1; end
            end
            default: ;
         endcase
         if (i_byte_last) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
            half_d  = 1'b0;
            if (nxt != DONE) begin
               done_d  = 1'b1;
               found_d = 1'b0;
               err_d   = nxt != NOSNI;
               len_d   = 16'd0;
            end
         end else state_d = nxt;
      end
   end
   // state and output registers, cleared asynchronously
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= IDLE;
         cnt_q      <= 16'd0;
         acc_q      <= 8'd0;
         ext_q      <= 16'd0;
         typ0_q     <= 1'b0;
         name_len_q <= 16'd0;
         half_q     <= 1'b0;
         hi_q       <= 8'd0;
         data_q     <= 16'd0;
         fin_q      <= 1'b0;
         mrst_q     <= 1'b0;
         dv_q       <= 1'b0;
         done_q     <= 1'b0;
         found_q    <= 1'b0;
         err_q      <= 1'b0;
         len_q      <= 16'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         ext_q      <= ext_d;
         typ0_q     <= typ0_d;
         name_len_q <= name_len_d;
         half_q     <= half_d;
         hi_q       <= hi_d;
         data_q     <= data_d;
         fin_q      <= fin_d;
         mrst_q     <= mrst_d;
         dv_q       <= dv_d;
         done_q     <= done_d;
         found_q    <= found_d;
         err_q      <= err_d;
         len_q      <= len_d;
      end
   end
   assign o_match_rst        = mrst_q;
   assign o_match_data_valid = dv_q;
   assign o_match_data       = data_q;
   assign o_sni_done         = done_q;
   assign o_sni_found        = found_q;
   assign o_parse_err        = err_q;
   assign o_sni_len          = len_q;
endmodule

// File: tb/tb_tls_sni_extractor.sv
// tb_tls_sni_extractor: scoreboard bench with a byte-array ClientHello reference parser.
module tb_tls_sni_extractor;
   logic        clk = 1'b0, rst;
   logic        i_byte_valid, i_byte_last;
   logic [7:0]  i_byte;
   logic        o_match_rst, o_match_data_valid, o_sni_done, o_sni_found, o_parse_err;
   logic [15:0] o_match_data, o_sni_len;
   typedef struct packed {logic [1:0] kind; logic found; logic err; logic [15:0] val;} ev_t;
   ev_t exp_q[$];
   int  tests = 0, fails = 0;
   logic prev_ev;

   tls_sni_extractor dut (
      .i_clk(clk), .i_rst(rst), .i_byte_valid(i_byte_valid), .i_byte(i_byte), .i_byte_last(i_byte_last),
      .o_match_rst(o_match_rst), .o_match_data_valid(o_match_data_valid), .o_match_data(o_match_data),
      .o_sni_done(o_sni_done), .o_sni_found(o_sni_found), .o_parse_err(o_parse_err), .o_sni_len(o_sni_len)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] lc(input logic [7:0] b);
`ifdef SNI_LOWERCASE_EN
      return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
`else
      return b;
`endif
   endfunction

   function automatic void push(input logic [1:0] k, input logic f, input logic e, input logic [15:0] v);
      ev_t x;
      x.kind = k; x.found = f; x.err = e; x.val = v;
      exp_q.push_back(x);
   endfunction

   // walks the packet by field offsets; returns 0 found, 1 list exhausted, 2 error/truncated
   function automatic int parse(input logic [7:0] p[$], output int nl);
      int n, i, e_end, t, l;
      n = p.size(); nl = 0;
      if (n < 6 || p[0] != 8'h16 || p[5] != 8'h01) return 2;
      i = 43;
      if (i >= n) return 2;
      i = i + 1 + int'(p[i]);
      if (i + 2 > n) return 2;
      i = i + 2 + int'({p[i], p[i+1]});
      if (i >= n) return 2;
      i = i + 1 + int'(p[i]);
      if (i + 2 > n) return 2;
      e_end = i + 2 + int'({p[i], p[i+1]});
      i = i + 2;
      while (i < e_end) begin
         if (i + 4 > n) return 2;
         t = int'({p[i], p[i+1]});
         l = int'({p[i+2], p[i+3]});
         i = i + 4;
         if (t == 0) begin
            if (i + 3 > n || p[i+2] != 8'h00 || i + 5 > n) return 2;
            nl = int'({p[i+3], p[i+4]});
            i = i + 5;
            if (nl > 255) return 2;
            push(2'd0, 1'b0, 1'b0, 16'd0);
            for (int k = 0; k + 1 < nl && i + k + 1 < n; k += 2) push(2'd1, 1'b0, 1'b0, {lc(p[i+k]), lc(p[i+k+1])});
            if (i + nl > n) return 2;
            if (nl % 2 == 1) push(2'd1, 1'b0, 1'b0, {lc(p[i+nl-1]), 8'h00});
            return 0;
         end
         i = i + l;
         if (i > n) return 2;
      end
      return 1;
   endfunction

   function automatic void model(input logic [7:0] p[$], input bit hl);
      int nl, v;
      v = parse(p, nl);
      if (v == 0 || hl) push(2'd2, v == 0, v == 2, (v == 0) ? 16'(nl) : 16'd0);
   endfunction

   function automatic void build(output logic [7:0] p[$], input int sid, input int cs, input int cm,
                                 input logic [15:0] pt[$], input int pl[$], input bit sni,
                                 input logic [7:0] ntype, input logic [7:0] nm[$], input int npost);
      logic [7:0] e[$];
      int L;
      foreach (pt[j]) begin
         e.push_back(pt[j][15:8]); e.push_back(pt[j][7:0]);
         e.push_back(8'(pl[j] >> 8)); e.push_back(8'(pl[j]));
         repeat (pl[j]) e.push_back(8'($urandom));
      end
      if (sni) begin
         L = nm.size();
         e.push_back(8'h00); e.push_back(8'h00);
         e.push_back(8'((L + 5) >> 8)); e.push_back(8'(L + 5));
         e.push_back(8'((L + 3) >> 8)); e.push_back(8'(L + 3));
         e.push_back(ntype); e.push_back(8'(L >> 8)); e.push_back(8'(L));
         foreach (nm[j]) e.push_back(nm[j]);
      end
      repeat (npost) begin
         e.push_back(8'h00); e.push_back(8'h10); e.push_back(8'h00); e.push_back(8'h02);
         e.push_back(8'($urandom)); e.push_back(8'($urandom));
      end
      p = {8'h16, 8'h03, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
      repeat (34) p.push_back(8'($urandom));
      p.push_back(8'(sid));
      repeat (sid) p.push_back(8'($urandom));
      p.push_back(8'(cs >> 8)); p.push_back(8'(cs));
      repeat (cs) p.push_back(8'($urandom));
      p.push_back(8'(cm));
      repeat (cm) p.push_back(8'($urandom));
      p.push_back(8'(e.size() >> 8)); p.push_back(8'(e.size()));
      foreach (e[j]) p.push_back(e[j]);
   endfunction

   task automatic send(input logic [7:0] p[$], input bit hl);
      foreach (p[j]) begin
         while ($urandom_range(3) == 0) begin @(negedge clk); i_byte_valid = 1'b0; i_byte_last = 1'b0; end
         @(negedge clk);
         i_byte_valid = 1'b1; i_byte = p[j]; i_byte_last = hl && (j == p.size() - 1);
      end
      @(negedge clk);
      i_byte_valid = 1'b0; i_byte_last = 1'b0;
   endtask

   task automatic run(input logic [7:0] p[$], input bit hl);
      model(p, hl);
      send(p, hl);
   endtask

   task automatic rand_pkt(output logic [7:0] p[$]);
      logic [15:0] pt[$];
      logic [7:0]  nm[$];
      int pl[$];
      int r, nl, c, n2;
      repeat ($urandom_range(2)) begin pt.push_back(16'($urandom_range(1, 65535))); pl.push_back($urandom_range(6)); end
      r  = $urandom_range(9);
      nl = (r == 0) ? $urandom_range(256, 262) : (r == 1) ? 255 : $urandom_range(1, 20);
      repeat (nl) nm.push_back(8'($urandom_range(8'h2D, 8'h7A)));
      build(p, ($urandom_range(3) == 0) ? 32 : $urandom_range(8), 2 * $urandom_range(4), $urandom_range(2),
            pt, pl, $urandom_range(3) != 0, ($urandom_range(7) == 0) ? 8'h01 : 8'h00, nm, $urandom_range(1));
      c = $urandom_range(9);
      if (c == 0) p[0] = 8'h17;
      else if (c == 1) p[5] = 8'h02;
      else if (c <= 3) begin
         n2 = $urandom_range(2, p.size() - 1);
         while (p.size() > n2) void'(p.pop_back());
      end else repeat ($urandom_range(2)) p.push_back(8'($urandom));
   endtask

   task automatic check_ev(input logic [1:0] kind, input logic [15:0] val, input logic found, input logic err,
                           input logic tim_ok, input string nm);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL %s unexpected: got val=%h found=%0d err=%0d, required no event", nm, val, found, err);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val || e.found != found || e.err != err) begin
            fails++;
            $display("FAIL %s: got kind=%0d val=%h found=%0d err=%0d, required kind=%0d val=%h found=%0d err=%0d",
                     nm, kind, val, found, err, e.kind, e.val, e.found, e.err);
         end
      end
      tests++;
      if (!tim_ok) begin
         fails++;
         $display("FAIL %s timing: got event without its triggering input cycle, required latency 1", nm);
      end
   endtask

   // monitor: one sample per cycle, just after the active edge
   initial begin
      prev_ev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            if (o_match_rst) check_ev(2'd0, 16'd0, 1'b0, 1'b0, i_byte_valid, "match_rst");
            if (o_match_data_valid) check_ev(2'd1, o_match_data, 1'b0, 1'b0, i_byte_valid, "word");
            if (o_sni_done) check_ev(2'd2, o_sni_len, o_sni_found, o_parse_err,
                                     o_sni_found ? prev_ev : (i_byte_valid && i_byte_last), "done");
         end
         prev_ev = o_match_data_valid | o_match_rst;
      end
   end

   initial begin
      logic [7:0]  p[$], q[$], nm[$];
      logic [15:0] pt[$], none_t[$];
      int          pl[$], none_l[$];
      rst = 1'b1; i_byte_valid = 1'b0; i_byte_last = 1'b0; i_byte = 8'h00;
      repeat (3) @(negedge clk);
      tests++;
      if ({o_match_rst, o_match_data_valid, o_match_data, o_sni_done, o_sni_found, o_parse_err, o_sni_len} != '0) begin
         fails++;
         $display("FAIL reset outputs: got nonzero, required all 0");
      end
      rst = 1'b0;
      @(negedge clk);
      nm = {8'h61, 8'h62, 8'h2E, 8'h63, 8'h6F, 8'h6D};
      build(p, 32, 4, 1, none_t, none_l, 1'b1, 8'h00, nm, 0);
      run(p, 1'b1);
      q = p; q[0] = 8'h17;
      run(q, 1'b1);
      q = p;
      while (q.size() > 80) void'(q.pop_back());
      run(q, 1'b1);
      run(p, 1'b1);
      pt = {16'h000A}; pl = {4};
      nm = {8'h61, 8'h62, 8'h63};
      build(p, 32, 4, 1, pt, pl, 1'b1, 8'h00, nm, 1);
      run(p, 1'b1);
      pt = {16'h000A, 16'h000D}; pl = {4, 2};
      build(p, 0, 2, 0, pt, pl, 1'b0, 8'h00, nm, 0);
      run(p, 1'b1);
      nm = {8'h41, 8'h42, 8'h2E, 8'h43, 8'h6F, 8'h6D};
      build(p, 8, 2, 1, none_t, none_l, 1'b1, 8'h00, nm, 0);
      run(p, 1'b1);
      nm = {8'h61, 8'h62, 8'h63, 8'h64};
      build(p, 0, 2, 1, none_t, none_l, 1'b1, 8'h00, nm, 0);
      q = p;
      void'(q.pop_back()); void'(q.pop_back());
      run(q, 1'b0);
      #1 rst = 1'b1;
      #1;
      tests++;
      if ({o_match_rst, o_match_data_valid, o_sni_done} != 3'b000) begin
         fails++;
         $display("FAIL async reset: got rst/dv/done=%b, required 000", {o_match_rst, o_match_data_valid, o_sni_done});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run(p, 1'b1);
      repeat (150) begin
         rand_pkt(p);
         run(p, 1'b1);
         repeat ($urandom_range(2)) @(negedge clk);
      end
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d events still pending, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
